// File: rtl/mem_bank_write_ctrl.sv
// Write-side front end for the multi-bank register memory: host FIFO drained onto the write port in granted cycles.
// Optional post-reset default-value sweep of every bank/address, enabled by `define MEM_BANK_CLEAR_SWEEP_EN.
module mem_bank_write_ctrl #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    DEPTH         = 256,
   parameter int                    NUM_BANKS     = 2,
   parameter int                    BANK_WIDTH    = $clog2(NUM_BANKS),
   parameter int                    FIFO_DEPTH    = 4,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            host_valid,
   output logic                            host_ready,
   input  logic [BANK_WIDTH-1:0]           host_bank,
   input  logic [$clog2(DEPTH)-1:0]        host_addr,
   input  logic [DATA_WIDTH-1:0]           host_data,
   input  logic                            wr_grant,
   output logic                            wea,
   output logic [BANK_WIDTH-1:0]           banka,
   output logic [$clog2(DEPTH)-1:0]        addra,
   output logic [DATA_WIDTH-1:0]           dia,
   output logic                            init_busy,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int ADDR_W  = $clog2(DEPTH);
   localparam int IDX_W   = $clog2(FIFO_DEPTH);
   localparam int PTR_W   = IDX_W + 1;
   localparam int ENTRY_W = BANK_WIDTH + ADDR_W + DATA_WIDTH;

   logic [ENTRY_W-1:0]    fifo_mem_q [FIFO_DEPTH];
   logic [ENTRY_W-1:0]    fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic                  wea_q, wea_d;
   logic [BANK_WIDTH-1:0] banka_q, banka_d;
   logic [ADDR_W-1:0]     addra_q, addra_d;
   logic [DATA_WIDTH-1:0] dia_q, dia_d;

   logic [PTR_W-1:0]      level;
   logic                  full, empty, push, pop, in_run, busy;

`ifdef MEM_BANK_CLEAR_SWEEP_EN
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);
   localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t                state_q, state_d;
   logic [BANK_WIDTH-1:0] sweep_bank_q, sweep_bank_d;
   logic [ADDR_W-1:0]     sweep_addr_q, sweep_addr_d;

   assign in_run = (state_q == ST_RUN);
   assign busy   = (state_q == ST_CLEAR);
`else
   assign in_run = 1'b1;
   assign busy   = 1'b0;
`endif

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level      = wr_ptr_q - rd_ptr_q;
   assign full       = (level == PTR_W'(FIFO_DEPTH));
   assign empty      = (level == '0);
   assign host_ready = !full && !busy;
   assign push       = host_valid && host_ready;
   assign pop        = !empty && wr_grant && in_run;

   always_comb begin
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      wea_d      = 1'b0;
      banka_d    = banka_q;
      addra_d    = addra_q;
      dia_d      = dia_q;

      if (push) begin
         fifo_mem_d[wr_ptr_q[IDX_W-1:0]] = {host_bank, host_addr, host_data};
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         {banka_d, addra_d, dia_d} = fifo_mem_q[rd_ptr_q[IDX_W-1:0]];
         wea_d    = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

`ifdef MEM_BANK_CLEAR_SWEEP_EN
      state_d      = state_q;
      sweep_bank_d = sweep_bank_q;
      sweep_addr_d = sweep_addr_q;

      // The sweep owns the write port and ignores wr_grant; address runs fastest.
      if (state_q == ST_CLEAR) begin
         wea_d        = 1'b1;
         banka_d      = sweep_bank_q;
         addra_d      = sweep_addr_q;
         dia_d        = DEFAULT_VALUE;
         sweep_addr_d = sweep_addr_q + ADDR_W'(1);
         if (sweep_addr_q == LAST_ADDR) begin
            sweep_bank_d = sweep_bank_q + BANK_WIDTH'(1);
            if (sweep_bank_q == LAST_BANK) begin
               state_d = ST_RUN;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         wea_q        <= 1'b0;
         banka_q      <= '0;
         addra_q      <= '0;
         dia_q        <= '0;
`ifdef MEM_BANK_CLEAR_SWEEP_EN
         state_q      <= ST_CLEAR;
         sweep_bank_q <= '0;
         sweep_addr_q <= '0;
`endif
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         wea_q        <= wea_d;
         banka_q      <= banka_d;
         addra_q      <= addra_d;
         dia_q        <= dia_d;
`ifdef MEM_BANK_CLEAR_SWEEP_EN
         state_q      <= state_d;
         sweep_bank_q <= sweep_bank_d;
         sweep_addr_q <= sweep_addr_d;
`endif
      end
   end

   // Entry storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      fifo_mem_q <= fifo_mem_d;
   end

   assign wea        = wea_q;
   assign banka      = banka_q;
   assign addra      = addra_q;
   assign dia        = dia_q;
   assign init_busy  = busy;
   assign fifo_level = level;

endmodule

// File: tb/tb_mem_bank_write_ctrl.sv
// Directed bench for mem_bank_write_ctrl; the sweep section runs when MEM_BANK_CLEAR_SWEEP_EN is defined.
module tb_mem_bank_write_ctrl;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 256;
   localparam int NUM_BANKS  = 2;
   localparam int BANK_WIDTH = 1;
   localparam int FIFO_DEPTH = 4;
   localparam int ADDR_W     = 8;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  host_valid = 1'b0;
   logic                  host_ready;
   logic [BANK_WIDTH-1:0] host_bank = '0;
   logic [ADDR_W-1:0]     host_addr = '0;
   logic [DATA_WIDTH-1:0] host_data = '0;
   logic                  wr_grant = 1'b0;
   logic                  wea;
   logic [BANK_WIDTH-1:0] banka;
   logic [ADDR_W-1:0]     addra;
   logic [DATA_WIDTH-1:0] dia;
   logic                  init_busy;
   logic [2:0]            fifo_level;

   int n_vec = 0;
   int n_err = 0;

   mem_bank_write_ctrl #(
      .DATA_WIDTH   (DATA_WIDTH),
      .DEPTH        (DEPTH),
      .NUM_BANKS    (NUM_BANKS),
      .BANK_WIDTH   (BANK_WIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .DEFAULT_VALUE(8'h00)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .host_valid (host_valid),
      .host_ready (host_ready),
      .host_bank  (host_bank),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .wr_grant   (wr_grant),
      .wea        (wea),
      .banka      (banka),
      .addra      (addra),
      .dia        (dia),
      .init_busy  (init_busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_entry(input logic b, input logic [7:0] a, input logic [7:0] d);
      host_valid = 1'b1;
      host_bank  = b;
      host_addr  = a;
      host_data  = d;
      tick();
      host_valid = 1'b0;
   endtask

`ifdef MEM_BANK_CLEAR_SWEEP_EN
   task automatic full_sweep_check();
      chk("sw_busy0", init_busy, 1);
      chk("sw_rdy0", host_ready, 0);
      chk("sw_wea0", wea, 0);
      host_valid = 1'b1;
      host_data  = 8'h77;
      for (int i = 0; i < NUM_BANKS * DEPTH; i++) begin
         tick();
         if (i == 509) host_valid = 1'b0;
         chk("sw_wea", wea, 1);
         chk("sw_bank", banka, i / DEPTH);
         chk("sw_addr", addra, i % DEPTH);
         chk("sw_dia", dia, 0);
         chk("sw_busy", init_busy, (i < NUM_BANKS * DEPTH - 1) ? 1 : 0);
         chk("sw_rdy", host_ready, (i == NUM_BANKS * DEPTH - 1) ? 1 : 0);
      end
      tick();
      chk("sw_end_wea", wea, 0);
      chk("sw_end_lvl", fifo_level, 0);
   endtask
`endif

   task automatic wait_ready();
      int n;
      n = 0;
      while (init_busy && n < 600) begin
         tick();
         n++;
      end
      chk("init_timeout", init_busy, 0);
   endtask

   logic [16:0] expq[$];
   logic [16:0] e;
   logic        accept, prev_grant;
   int          sent, writes;

   initial begin
      // reset values
      repeat (3) tick();
      chk("rst_wea", wea, 0);
      chk("rst_bank", banka, 0);
      chk("rst_addr", addra, 0);
      chk("rst_dia", dia, 0);
      chk("rst_lvl", fifo_level, 0);
`ifdef MEM_BANK_CLEAR_SWEEP_EN
      chk("rst_busy", init_busy, 1);
      chk("rst_rdy", host_ready, 0);
      reset_n = 1'b1;
      // partial sweep, then reset at addr 100
      for (int i = 0; i < 101; i++) tick();
      chk("mid_addr", addra, 100);
      chk("mid_wea", wea, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_wea", wea, 0);
      chk("mid_rst_addr", addra, 0);
      chk("mid_rst_busy", init_busy, 1);
      tick();
      reset_n = 1'b1;
      full_sweep_check();
`else
      chk("rst_busy", init_busy, 0);
      chk("rst_rdy", host_ready, 1);
      reset_n = 1'b1;
      tick();
      chk("run_wea", wea, 0);
`endif

      // single write, two edges after acceptance
      wr_grant = 1'b1;
      push_entry(1'b1, 8'h20, 8'hA5);
      chk("one_nobypass", wea, 0);
      chk("one_lvl1", fifo_level, 1);
      tick();
      chk("one_wea", wea, 1);
      chk("one_bank", banka, 1);
      chk("one_addr", addra, 8'h20);
      chk("one_dia", dia, 8'hA5);
      chk("one_lvl0", fifo_level, 0);
      tick();
      chk("one_pulse", wea, 0);
      chk("one_hold", {banka, addra, dia}, {1'b1, 8'h20, 8'hA5});

      // fill with grant low: 4 accepted, 5th refused
      wr_grant = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("fill_rdy", host_ready, (i < 4) ? 1 : 0);
         host_valid = 1'b1;
         host_bank  = 1'(i);
         host_addr  = 8'(8'h40 + i);
         host_data  = 8'(8'h10 + i);
         tick();
         chk("fill_wea", wea, 0);
      end
      chk("fill_lvl", fifo_level, 4);
      // full with pop this cycle: push still refused
      host_data = 8'hEE;
      wr_grant  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         host_valid = 1'b0;
         chk("drain_wea", wea, 1);
         chk("drain_bank", banka, i % 2);
         chk("drain_addr", addra, 8'h40 + i);
         chk("drain_dia", dia, 8'h10 + i);
         chk("drain_lvl", fifo_level, 3 - i);
      end
      tick();
      chk("drain_done", wea, 0);

      // level 2, simultaneous push and pop
      wr_grant = 1'b0;
      push_entry(1'b0, 8'h01, 8'hA1);
      push_entry(1'b1, 8'h02, 8'hB2);
      chk("pp_lvl2", fifo_level, 2);
      wr_grant   = 1'b1;
      host_valid = 1'b1;
      host_bank  = 1'b0;
      host_addr  = 8'h03;
      host_data  = 8'hC3;
      tick();
      host_valid = 1'b0;
      chk("pp_lvl", fifo_level, 2);
      chk("pp_first", {wea, dia}, {1'b1, 8'hA1});
      tick();
      chk("pp_second", {wea, banka, addra, dia}, {1'b1, 1'b1, 8'h02, 8'hB2});
      tick();
      chk("pp_third", {wea, banka, addra, dia}, {1'b1, 1'b0, 8'h03, 8'hC3});
      tick();
      chk("pp_empty", {wea, fifo_level}, 4'b0000);

      // grant toggling with continuous host stream
      sent = 0;
      writes = 0;
      wr_grant = 1'b1;
      for (int c = 0; c < 60; c++) begin
         host_valid = (sent < 8);
         host_bank  = 1'(sent);
         host_addr  = 8'(8'h10 + sent);
         host_data  = 8'(8'h30 + sent);
         accept = host_valid && host_ready;
         if (accept) expq.push_back({host_bank, host_addr, host_data});
         prev_grant = wr_grant;
         tick();
         if (accept) sent++;
         if (wea) begin
            chk("tog_gate", prev_grant, 1);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("tog_data", {banka, addra, dia}, e);
            end else begin
               chk("tog_extra", wea, 0);
            end
            writes++;
         end
         wr_grant = ~wr_grant;
      end
      host_valid = 1'b0;
      chk("tog_count", writes, 8);
      chk("tog_left", expq.size(), 0);
      chk("tog_lvl", fifo_level, 0);

      // reset mid-drain with entries buffered
      wr_grant = 1'b0;
      push_entry(1'b1, 8'h55, 8'h5A);
      push_entry(1'b1, 8'h56, 8'h5B);
      push_entry(1'b1, 8'h57, 8'h5C);
      wr_grant = 1'b1;
      tick();
      chk("rd_wea_pre", wea, 1);
      reset_n = 1'b0;
      #1;
      chk("rd_wea", wea, 0);
      chk("rd_lvl", fifo_level, 0);
      tick();
      reset_n = 1'b1;
`ifdef MEM_BANK_CLEAR_SWEEP_EN
      wr_grant = 1'b0;
      tick();
      chk("rd_restart", {wea, banka, addra}, {1'b1, 1'b0, 8'h00});
      wait_ready();
      wr_grant = 1'b1;
      tick();
`else
      wait_ready();
`endif
      writes = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (wea) writes++;
      end
      chk("rd_nostale", writes, 0);
      chk("rd_lvl_end", fifo_level, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
